// File: rtl/cpu_io_pkg.sv
// rtl/cpu_io_pkg.sv - shared address map and enums for the CPU memory/IO bridge
package cpu_io_pkg;

    // I/O window select on a[17:16] and the decoded I/O register addresses
    localparam logic [1:0]  IO_SEL       = 2'b11;
    localparam logic [17:0] IO_UART_ADDR = 18'h30000;
    localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

    // Source of cpu_din in the cycle after an access
    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_RX,
        SEL_CLK,
        SEL_ZERO
    } rd_sel_e;

    // Program-stop sequencer
    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_EMIT_NUL,
        ST_HALT
    } stop_st_e;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - byte FIFO with same-cycle push+pop accepted when full
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   push, push_data      enqueue request and byte (dropped when full unless popping)
//   pop                  dequeue request (ignored when empty)
//   head                 oldest byte, valid while !empty
//   empty, full          status of the registered occupancy
//   count, count_next    current occupancy and the occupancy after this cycle
// DEPTH must be a power of two and at least 4.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign head    = mem[rd_ptr];
    // When full, a simultaneous pop frees the slot the push overwrites
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop);

    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - CPU memory port decoder: RAM, UART TX FIFO / RX, cycle counter, stop sequencer
//
// Ports:
//   clk_in, rst_in                       clock, synchronous active-low reset
//   rdy_in                               global ready; low freezes CPU accesses and the counter
//   cpu_a, cpu_dout, cpu_wr, cpu_din     CPU byte port; cpu_din valid one cycle after a read
//   io_buffer_full                       TX FIFO near-full flag back to the CPU
//   ram_a, ram_dout, ram_wr, ram_din     synchronous RAM port (1-cycle read latency)
//   tx_data, tx_valid, tx_ready          byte stream to the UART transmitter
//   rx_data, rx_valid, rx_pop            UART receive byte and its consume pulse
//   prog_stop                            sticky program-finished flag
//   addr_err                             sticky out-of-range flag (BRIDGE_RANGE_CHECK_EN only)
// Macro BRIDGE_RANGE_CHECK_EN: treat a[17:16]==2'b10 as out-of-range instead of aliasing RAM.
module mem_io_bridge #(
    parameter int FIFO_DEPTH  = 16,
    parameter int FULL_MARGIN = 2,
    parameter int RAM_AW      = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [31:0]       cpu_a,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_din,
    output logic              io_buffer_full,
    output logic [RAM_AW-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_pop,
    output logic              prog_stop
`ifdef BRIDGE_RANGE_CHECK_EN
    ,
    output logic              addr_err
`endif
);
    import cpu_io_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [17:0]   addr;
    logic          is_io, is_oor, is_uart, is_clk, is_clk_lo;
    logic          acc, wr_en, push;
    logic          unused_hi;
    rd_sel_e       sel_q;
    logic [7:0]    data_q;
    logic [31:0]   counter;
    logic [31:0]   snapshot;
    stop_st_e      state;
    logic [7:0]    fifo_head;
    logic          fifo_empty, fifo_pop;
    logic          unused_fifo_status;
    logic          fifo_full;
    logic [CW-1:0] fifo_count, fifo_count_next;

    assign addr      = cpu_a[17:0];
    assign unused_hi = ^cpu_a[31:18];
    assign is_io     = (addr[17:16] == IO_SEL);
`ifdef BRIDGE_RANGE_CHECK_EN
    assign is_oor    = (addr[17:16] == 2'b10);
`else
    assign is_oor    = 1'b0;
`endif
    assign is_uart   = (addr == IO_UART_ADDR);
    assign is_clk_lo = (addr == IO_CLK_ADDR);
    assign is_clk    = (addr[17:2] == IO_CLK_ADDR[17:2]);

    // Pass-through outputs are gated by reset so they read 0 while held in reset
    assign acc      = rst_in && rdy_in;
    assign wr_en    = acc && cpu_wr && (state != ST_HALT);
    assign ram_a    = rst_in ? cpu_a[RAM_AW-1:0] : '0;
    assign ram_dout = rst_in ? cpu_dout : 8'h00;
    assign ram_wr   = wr_en && !is_io && !is_oor;
    assign rx_pop   = acc && !cpu_wr && is_uart && rx_valid;

    // NUL bytes are the stop marker, so the CPU can never queue one itself
    assign push     = wr_en && is_uart && (cpu_dout != 8'h00) &&
                      ((state == ST_RUN) || (state == ST_DRAIN));
    assign fifo_pop = !fifo_empty && tx_ready;

    assign tx_valid = (state == ST_EMIT_NUL) || !fifo_empty;
    assign tx_data  = (state == ST_EMIT_NUL) ? 8'h00 : fifo_head;

    assign unused_fifo_status = ^{fifo_full, fifo_count};

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk        (clk_in),
        .resetn     (rst_in),
        .push       (push),
        .push_data  (cpu_dout),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    // RAM data arrives straight from the synchronous RAM; I/O data is registered here
    always_comb begin
        cpu_din = 8'h00;
        case (sel_q)
            SEL_RAM:         cpu_din = ram_din;
            SEL_RX, SEL_CLK: cpu_din = data_q;
            default:         cpu_din = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sel_q          <= SEL_ZERO;
            data_q         <= 8'h00;
            counter        <= '0;
            snapshot       <= '0;
            state          <= ST_RUN;
            prog_stop      <= 1'b0;
            io_buffer_full <= 1'b0;
`ifdef BRIDGE_RANGE_CHECK_EN
            addr_err       <= 1'b0;
`endif
        end else begin
            io_buffer_full <= (FIFO_DEPTH - int'(fifo_count_next)) <= FULL_MARGIN;

            if (rdy_in) begin
                counter <= counter + 32'd1;
                sel_q   <= SEL_ZERO;
                data_q  <= 8'h00;
                if (!cpu_wr && !is_oor) begin
                    if (!is_io) begin
                        sel_q <= SEL_RAM;
                    end else if (is_uart) begin
                        sel_q  <= SEL_RX;
                        data_q <= rx_valid ? rx_data : 8'h00;
                    end else if (is_clk) begin
                        sel_q <= SEL_CLK;
                        // Reading byte 0 latches the whole counter so bytes 1..3 match it
                        if (addr[1:0] == 2'b00) begin
                            snapshot <= counter;
                            data_q   <= counter[7:0];
                        end else begin
                            data_q <= snapshot[{addr[1:0], 3'b000} +: 8];
                        end
                    end
                end
`ifdef BRIDGE_RANGE_CHECK_EN
                if (is_oor) addr_err <= 1'b1;
`endif
            end

            case (state)
                ST_RUN:      if (wr_en && is_clk_lo) state <= ST_DRAIN;
                ST_DRAIN:    if (fifo_empty && !push) state <= ST_EMIT_NUL;
                ST_EMIT_NUL: if (tx_ready) begin
                                 state     <= ST_HALT;
                                 prog_stop <= 1'b1;
                             end
                ST_HALT:     state <= ST_HALT;
                default:     state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - scoreboard bench for mem_io_bridge
module tb_mem_io_bridge;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic [31:0] cpu_a = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_pop;
    logic        prog_stop;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  mon_exp;
    logic [7:0]  rd_exp;
    logic [31:0] mcnt;
    logic [7:0]  mem [0:131071];

    mem_io_bridge dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_dout       (ram_dout),
        .ram_wr         (ram_wr),
        .ram_din        (ram_din),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (rx_pop),
        .prog_stop      (prog_stop)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM model
    always @(posedge clk_in) begin
        if (ram_wr) mem[ram_a] <= ram_dout;
        ram_din <= mem[ram_a];
    end

    // Reference cycle counter
    always @(posedge clk_in) begin
        if (!rst_in)     mcnt <= '0;
        else if (rdy_in) mcnt <= mcnt + 32'd1;
    end

    // TX scoreboard: every accepted byte must match the oldest expected byte
    always @(negedge clk_in) begin
        if (rst_in && tx_valid && tx_ready) begin
            n_checks++;
            if (tx_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: got %02h, no byte expected", tx_data);
            end else begin
                mon_exp = tx_q.pop_front();
                if (tx_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL tx_data: got %02h expected %02h", tx_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
        cpu_a = a; cpu_dout = d; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic drain_tx(input string name);
        for (int i = 0; i < 300 && (tx_q.size() != 0 || tx_valid); i++) tick();
        n_checks++;
        if (tx_q.size() != 0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: %0d bytes pending, tx_valid=%b, expected 0 and 0", name, tx_q.size(), tx_valid);
        end
    endtask

    task automatic test_reset();
        rdy_in = 1'b1; rst_in = 1'b0; tx_ready = 1'b0;
        cpu_a = 32'h0000_0123; cpu_dout = 8'hFF; cpu_wr = 1'b1;
        tick(); tick();
        n_checks++; if (ram_wr !== 1'b0)     begin n_fail++; $display("FAIL rst_ram_wr: got %b expected 0", ram_wr); end
        n_checks++; if (ram_a !== 17'h0)     begin n_fail++; $display("FAIL rst_ram_a: got %h expected 0", ram_a); end
        n_checks++; if (ram_dout !== 8'h00)  begin n_fail++; $display("FAIL rst_ram_dout: got %h expected 0", ram_dout); end
        cpu_wr = 1'b0; cpu_a = 32'h0003_0000; rx_valid = 1'b1; rx_data = 8'h77;
        #1;
        n_checks++; if (rx_pop !== 1'b0)     begin n_fail++; $display("FAIL rst_rx_pop: got %b expected 0", rx_pop); end
        n_checks++; if (cpu_din !== 8'h00)   begin n_fail++; $display("FAIL rst_cpu_din: got %h expected 0", cpu_din); end
        n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b expected 0", io_buffer_full); end
        n_checks++; if (tx_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
        n_checks++; if (prog_stop !== 1'b0)  begin n_fail++; $display("FAIL rst_prog_stop: got %b expected 0", prog_stop); end
        rx_valid = 1'b0; cpu_a = '0;
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_ram();
        cpu_a = 32'h0000_0123; cpu_dout = 8'hA5; cpu_wr = 1'b1;
        #1;
        n_checks++; if (ram_wr !== 1'b1)     begin n_fail++; $display("FAIL ram_wr: got %b expected 1", ram_wr); end
        n_checks++; if (ram_a !== 17'h00123) begin n_fail++; $display("FAIL ram_a: got %h expected 00123", ram_a); end
        n_checks++; if (ram_dout !== 8'hA5)  begin n_fail++; $display("FAIL ram_dout: got %h expected a5", ram_dout); end
        tick();
        cpu_wr = 1'b0;
        rd_q.push_back(8'hA5);
        tick();
        rd_exp = rd_q.pop_front();
        n_checks++; if (cpu_din !== rd_exp)  begin n_fail++; $display("FAIL ram_read: got %h expected %h", cpu_din, rd_exp); end
        // Region 2'b10 aliases RAM in the default build
        cpu_a = 32'h0002_0045; cpu_dout = 8'h3C; cpu_wr = 1'b1;
        #1;
        n_checks++; if (ram_wr !== 1'b1 || ram_a !== 17'h00045) begin n_fail++; $display("FAIL ram_alias: got wr=%b a=%h expected 1 00045", ram_wr, ram_a); end
        tick();
        cpu_wr = 1'b0; cpu_a = '0;
    endtask

    task automatic test_uart_tx();
        tx_ready = 1'b1;
        tx_q.push_back(8'h48);
        cpu_write(32'h0003_0000, 8'h48);
        cpu_write(32'h0003_0000, 8'h00);
        tx_q.push_back(8'h69);
        cpu_write(32'h0003_0000, 8'h69);
        drain_tx("uart_tx_drain");
    endtask

    task automatic test_fifo_full();
        logic exp_full;
        tx_ready = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            if (k <= 16) tx_q.push_back(8'(k));
            cpu_write(32'h0003_0000, 8'(k));
            exp_full = (k >= 14);
            n_checks++;
            if (io_buffer_full !== exp_full) begin
                n_fail++;
                $display("FAIL full_after_push%0d: got %b expected %b", k, io_buffer_full, exp_full);
            end
        end
        // Push and pop together on a full FIFO: both accepted, stays full
        tx_q.push_back(8'h77);
        cpu_a = 32'h0003_0000; cpu_dout = 8'h77; cpu_wr = 1'b1; tx_ready = 1'b1;
        tick();
        cpu_wr = 1'b0; tx_ready = 1'b0;
        n_checks++; if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL full_push_pop: got %b expected 1", io_buffer_full); end
        tx_ready = 1'b1;
        drain_tx("fifo_full_drain");
        n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL full_after_drain: got %b expected 0", io_buffer_full); end
    endtask

    task automatic test_io_reads();
        cpu_wr = 1'b0; cpu_a = 32'h0003_0000; rx_valid = 1'b1; rx_data = 8'h3C;
        #1;
        n_checks++; if (rx_pop !== 1'b1) begin n_fail++; $display("FAIL rx_pop_valid: got %b expected 1", rx_pop); end
        rd_q.push_back(8'h3C);
        tick();
        rx_valid = 1'b0;
        rd_exp = rd_q.pop_front();
        n_checks++; if (cpu_din !== rd_exp) begin n_fail++; $display("FAIL rx_read: got %h expected %h", cpu_din, rd_exp); end
        #1;
        n_checks++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL rx_pop_idle: got %b expected 0", rx_pop); end
        rd_q.push_back(8'h00);
        tick();
        rd_exp = rd_q.pop_front();
        n_checks++; if (cpu_din !== rd_exp) begin n_fail++; $display("FAIL rx_read_empty: got %h expected %h", cpu_din, rd_exp); end
        cpu_a = 32'h0003_0010;
        rd_q.push_back(8'h00);
        tick();
        rd_exp = rd_q.pop_front();
        n_checks++; if (cpu_din !== rd_exp) begin n_fail++; $display("FAIL io_other_read: got %h expected %h", cpu_din, rd_exp); end
        // rdy_in low: a UART write is not accepted (the TX scoreboard would flag it)
        rdy_in = 1'b0; tx_ready = 1'b1;
        cpu_a = 32'h0003_0000; cpu_dout = 8'h99; cpu_wr = 1'b1;
        repeat (5) tick();
        cpu_wr = 1'b0; rdy_in = 1'b1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rdy_low_write: tx_valid=%b expected 0", tx_valid); end
    endtask

    task automatic test_snapshot();
        logic [31:0] snap;
        cpu_wr = 1'b0; cpu_a = '0;
        repeat (100) tick();
        snap = mcnt;
        for (int i = 0; i < 4; i++) begin
            cpu_a = 32'h0003_0004 + 32'(i);
            rd_q.push_back(snap[8*i +: 8]);
            tick();
            rd_exp = rd_q.pop_front();
            n_checks++;
            if (cpu_din !== rd_exp) begin
                n_fail++;
                $display("FAIL snapshot_byte%0d: got %h expected %h", i, cpu_din, rd_exp);
            end
        end
        cpu_a = '0;
        repeat (300) tick();
        cpu_a = 32'h0003_0005;
        rd_q.push_back(snap[15:8]);
        tick();
        rd_exp = rd_q.pop_front();
        n_checks++; if (cpu_din !== rd_exp) begin n_fail++; $display("FAIL snapshot_reuse: got %h expected %h", cpu_din, rd_exp); end
        cpu_a = '0;
    endtask

    task automatic test_stop();
        tx_ready = 1'b0;
        tx_q.push_back(8'h11); cpu_write(32'h0003_0000, 8'h11);
        tx_q.push_back(8'h22); cpu_write(32'h0003_0000, 8'h22);
        tx_q.push_back(8'h33); cpu_write(32'h0003_0000, 8'h33);
        tx_q.push_back(8'h00); cpu_write(32'h0003_0004, 8'h01);
        cpu_a = '0;
        repeat (3) tick();
        n_checks++; if (prog_stop !== 1'b0 || tx_valid !== 1'b1) begin n_fail++; $display("FAIL stop_wait: prog_stop=%b tx_valid=%b expected 0 1", prog_stop, tx_valid); end
        tx_ready = 1'b1;
        for (int i = 0; i < 100 && prog_stop !== 1'b1; i++) tick();
        n_checks++; if (prog_stop !== 1'b1) begin n_fail++; $display("FAIL stop_halt: prog_stop=%b expected 1", prog_stop); end
        n_checks++; if (tx_q.size() != 0) begin n_fail++; $display("FAIL stop_sequence: %0d bytes pending expected 0", tx_q.size()); end
        cpu_a = 32'h0000_0123; cpu_dout = 8'h11; cpu_wr = 1'b1;
        #1;
        n_checks++; if (ram_wr !== 1'b0) begin n_fail++; $display("FAIL halt_ram_wr: got %b expected 0", ram_wr); end
        tick();
        cpu_wr = 1'b0;
        rd_q.push_back(8'hA5);
        tick();
        rd_exp = rd_q.pop_front();
        n_checks++; if (cpu_din !== rd_exp) begin n_fail++; $display("FAIL halt_ram_read: got %h expected %h", cpu_din, rd_exp); end
        cpu_write(32'h0003_0000, 8'h55);
        tick();
        n_checks++; if (tx_valid !== 1'b0 || prog_stop !== 1'b1) begin n_fail++; $display("FAIL halt_uart: tx_valid=%b prog_stop=%b expected 0 1", tx_valid, prog_stop); end
    endtask

    task automatic test_reset_drain();
        rst_in = 1'b0; tick(); rst_in = 1'b1;
        tx_q.delete();
        tx_ready = 1'b0;
        cpu_write(32'h0003_0000, 8'hA1);
        cpu_write(32'h0003_0000, 8'hA2);
        cpu_write(32'h0003_0004, 8'h01);
        cpu_a = '0;
        tick();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        n_checks++; if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL rd_tx_valid: got %b expected 0", tx_valid); end
        n_checks++; if (prog_stop !== 1'b0) begin n_fail++; $display("FAIL rd_prog_stop: got %b expected 0", prog_stop); end
        n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL rd_full: got %b expected 0", io_buffer_full); end
        cpu_a = 32'h0003_0004;
        rd_q.push_back(8'h00);
        tick();
        rd_exp = rd_q.pop_front();
        n_checks++; if (cpu_din !== rd_exp) begin n_fail++; $display("FAIL rd_counter: got %h expected %h", cpu_din, rd_exp); end
        cpu_a = '0;
        repeat (4) tick();
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rd_fsm_run: tx_valid=%b expected 0", tx_valid); end
        tx_ready = 1'b1;
        tx_q.push_back(8'h5A);
        cpu_write(32'h0003_0000, 8'h5A);
        drain_tx("rd_resume_drain");
        n_checks++; if (prog_stop !== 1'b0) begin n_fail++; $display("FAIL rd_no_stop: got %b expected 0", prog_stop); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_uart_tx();
        test_fifo_full();
        test_io_reads();
        test_snapshot();
        test_stop();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
